// File: rtl/m_win_checker_pkg.sv
// m_win_checker_pkg: direction and state encodings plus board mask and step helpers
package m_win_checker_pkg;

    localparam int MAX_CELLS = 4096;

    localparam logic [1:0] DIR_H  = 2'd0;
    localparam logic [1:0] DIR_V  = 2'd1;
    localparam logic [1:0] DIR_DR = 2'd2;
    localparam logic [1:0] DIR_DL = 2'd3;

    localparam logic [3:0] DIR_H_OH  = 4'b0001;
    localparam logic [3:0] DIR_V_OH  = 4'b0010;
    localparam logic [3:0] DIR_DR_OH = 4'b0100;
    localparam logic [3:0] DIR_DL_OH = 4'b1000;

    typedef enum logic [1:0] {IDLE, REDUCE, SELECT, EXPAND} state_t;

    function automatic logic [MAX_CELLS-1:0] col_last_clear(input int rows, input int cols);
        logic [MAX_CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols - 1; c++)
                m[r*cols+c] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAX_CELLS-1:0] col_first_clear(input int rows, input int cols);
        logic [MAX_CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < rows; r++)
            for (int c = 1; c < cols; c++)
                m[r*cols+c] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAX_CELLS-1:0] dir_mask(input logic [1:0] d, input int rows, input int cols);
        return (d == DIR_V) ? {MAX_CELLS{1'b1}} :
               (d == DIR_DL) ? col_first_clear(rows, cols) : col_last_clear(rows, cols);
    endfunction

    function automatic int dir_step(input logic [1:0] d, input int cols);
        return (d == DIR_H) ? 1 : (d == DIR_V) ? cols : (d == DIR_DR) ? cols + 1 : cols - 1;
    endfunction

endpackage

// File: rtl/m_win_checker_reduce_step.sv
// m_line_reduce_step: one shift-and-AND reduction of a bitmap along one direction
module m_line_reduce_step #(
    parameter int F = 42,
    parameter int STEP = 1,
    parameter logic [F-1:0] MASK = '1
) (
    input  logic [F-1:0] acc,
    output logic [F-1:0] nxt
);

    assign nxt = acc & (acc >> STEP) & MASK;

endmodule

// File: rtl/m_win_checker.sv
// m_win_checker: sequential Connect-N line detector reporting winner, direction, mask, draw and conflict
module m_win_checker
    import m_win_checker_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 7,
    parameter int SEQ_LEN = 4,
    parameter int PLAYERS = 2,
    localparam int F = ROWS * COLS,
    localparam int PW = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [PLAYERS*F-1:0] i_fields,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_win,
    output logic [PW-1:0]        o_winner,
    output logic [3:0]           o_dir,
    output logic [F-1:0]         o_win_mask,
    output logic                 o_conflict,
    output logic                 o_draw
);

    localparam int CW = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(SEQ_LEN - 2);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [F-1:0]  acc [PLAYERS][4];
    logic [F-1:0]  acc_nxt [PLAYERS][4];
    logic [F-1:0]  seed, exp_m, seed_sh, occ, seed_sel;
    logic          full, win_q, conflict_q;
    logic [PW-1:0] winner_q, sel_p;
    logic [1:0]    dir_q, sel_d;
    logic [PLAYERS-1:0] win_p;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_p
        for (genvar d = 0; d < 4; d++) begin : g_d
            localparam logic [MAX_CELLS-1:0] M = dir_mask(2'(d), ROWS, COLS);
            m_line_reduce_step #(
                .F(F),
                .STEP(dir_step(2'(d), COLS)),
                .MASK(M[F-1:0])
            ) u_step (
                .acc(acc[p][d]),
                .nxt(acc_nxt[p][d])
            );
        end
    end

    // Downward loops leave the lowest winning player and the highest-priority direction selected.
    always_comb begin
        occ = '0;
        win_p = '0;
        sel_p = '0;
        sel_d = DIR_H;
        for (int p = 0; p < PLAYERS; p++) begin
            occ |= i_fields[p*F +: F];
            win_p[p] = |(acc[p][0] | acc[p][1] | acc[p][2] | acc[p][3]);
        end
        for (int p = PLAYERS - 1; p >= 0; p--)
            if (win_p[p]) sel_p = PW'(p);
        for (int d = 3; d >= 0; d--)
            if (|acc[sel_p][d]) sel_d = 2'(d);
        seed_sel = acc[sel_p][sel_d];
    end

    assign seed_sh = seed << dir_step(dir_q, COLS);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            cnt <= '0;
            for (int p = 0; p < PLAYERS; p++)
                for (int d = 0; d < 4; d++)
                    acc[p][d] <= '0;
            seed <= '0;
            exp_m <= '0;
            full <= 1'b0;
            win_q <= 1'b0;
            conflict_q <= 1'b0;
            winner_q <= '0;
            dir_q <= DIR_H;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_win <= 1'b0;
            o_winner <= '0;
            o_dir <= '0;
            o_win_mask <= '0;
            o_conflict <= 1'b0;
            o_draw <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: if (i_start) begin
                    for (int p = 0; p < PLAYERS; p++)
                        for (int d = 0; d < 4; d++)
                            acc[p][d] <= i_fields[p*F +: F];
                    full <= &occ;
                    cnt <= '0;
                    o_busy <= 1'b1;
                    o_win <= 1'b0;
                    o_winner <= '0;
                    o_dir <= '0;
                    o_win_mask <= '0;
                    o_conflict <= 1'b0;
                    o_draw <= 1'b0;
                    state <= REDUCE;
                end
                REDUCE: begin
                    acc <= acc_nxt;
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    state <= (cnt == LAST) ? SELECT : REDUCE;
                end
                SELECT: begin
                    seed <= seed_sel;
                    exp_m <= seed_sel;
                    win_q <= |win_p;
                    conflict_q <= $countones(win_p) > 1;
                    winner_q <= sel_p;
                    dir_q <= sel_d;
                    state <= EXPAND;
                end
                EXPAND: begin
                    seed <= seed_sh;
                    exp_m <= exp_m | seed_sh;
                    cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                    if (cnt == LAST) begin
                        o_win_mask <= exp_m | seed_sh;
                        o_win <= win_q;
                        o_winner <= winner_q;
                        o_dir <= win_q ? 4'b0001 << dir_q : 4'b0000;
                        o_conflict <= conflict_q;
                        o_draw <= !win_q && full;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
